mnist_window_streamer: RTL

//  Producer side of the simpleCNN window interface (START/X/Y/IMGIN). Accepts one raster-order

---
 rtl/mnist_window_streamer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mnist_window_streamer.sv
// -----------------------------------------------------------------------------
// mnist_window_streamer
//
// Producer side of the simpleCNN window interface. Takes one raster-order
// grayscale frame (one pixel per accepted beat), keeps K-1 line buffers plus a
// KxK register window, and emits every fully-inside KxK window (stride 1) with
// its top-left coordinate, one cycle after the pixel that completes it.
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   START      in   1-cycle pulse: begin or restart a frame
//   PIX_IN     in   raster pixel, row 0 col 0 first
//   PIX_VALID  in   PIX_IN valid this cycle
//   BUSY       out  frame in progress
//   WIN_VALID  out  X/Y/IMGIN hold a new window this cycle
//   X          out  window top row
//   Y          out  window left column
//   IMGIN      out  window; IMGIN[(i*K+j)*PIX_W +: PIX_W] = pix[X+i][Y+j]
//   FRAME_DONE out  pulse coincident with the last window of the frame
// -----------------------------------------------------------------------------
module mnist_window_streamer #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 5,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 5
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   START,
    input  logic [PIX_W-1:0]       PIX_IN,
    input  logic                   PIX_VALID,
    output logic                   BUSY,
    output logic                   WIN_VALID,
    output logic [COORD_W-1:0]     X,
    output logic [COORD_W-1:0]     Y,
    output logic [K*K*PIX_W-1:0]   IMGIN,
    output logic                   FRAME_DONE
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // Packed [row][col][bit] so the flat layout matches IMGIN directly.
    typedef logic [K-1:0][K-1:0][PIX_W-1:0] win_t;

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [COORD_W-1:0]  x_q, x_d;
    logic [COORD_W-1:0]  y_q, y_d;
    win_t                imgin_q, imgin_d;

    // Datapath storage: no reset needed, every entry is rewritten before use.
    win_t                win_q, win_d;
    logic [PIX_W-1:0]    lb_q [K-1][IMG_W];

    logic [K-1:0][PIX_W-1:0] col_v;
    logic                accept;
    logic                emit;
    logic                last_pix;
    logic [RW-1:0]       x_full;
    logic [CW-1:0]       y_full;

    assign accept   = (state_q == S_STREAM) && PIX_VALID && !START;
    assign last_pix = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
    assign emit     = accept && (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
    assign x_full   = row_q - RW'(K-1);
    assign y_full   = col_q - CW'(K-1);

    // New column entering the window: K-1 buffered rows above plus the live pixel.
    // lb_q[0] holds the oldest row, lb_q[K-2] the row directly above.
    always_comb begin
        col_v = '0;
        for (int unsigned i = 0; i < K-1; i++) begin
            col_v[i] = lb_q[i][col_q];
        end
        col_v[K-1] = PIX_IN;
    end

    always_comb begin
        win_d = win_q;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K-1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][K-1] = col_v[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        imgin_d      = imgin_q;

        if (START) begin
            // START wins over any pixel on the same beat; an in-flight window is dropped.
            state_d = S_STREAM;
            col_d   = '0;
            row_d   = '0;
        end else if (accept) begin
            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (last_pix) begin
                state_d = S_IDLE;
                row_d   = '0;
            end
            if (emit) begin
                win_valid_d  = 1'b1;
                frame_done_d = last_pix;
                x_d          = COORD_W'(x_full);
                y_d          = COORD_W'(y_full);
                imgin_d      = win_d;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            imgin_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            x_q          <= x_d;
            y_q          <= y_d;
            imgin_q      <= imgin_d;
        end
    end

    // Line buffers act as a K-1 deep vertical shift per column.
    always_ff @(posedge CLK) begin
        if (accept) begin
            win_q <= win_d;
            for (int unsigned i = 0; i < K-2; i++) begin
                lb_q[i][col_q] <= lb_q[i+1][col_q];
            end
            lb_q[K-2][col_q] <= PIX_IN;
        end
    end

    assign BUSY       = (state_q == S_STREAM);
    assign WIN_VALID  = win_valid_q;
    assign FRAME_DONE = frame_done_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign IMGIN      = imgin_q;

endmodule
